l2_mem_responder: RTL and testbench

Main-memory responder for the L2 side of the cache hierarchy. It accepts line read and line write-back requests from the L2 controller, models a fixed access latency with a counter-driven state machine, and keeps the written lines in an internal backing store. It answers each request with a single-cycle `ready_MEM_L2` pulse, plus the fill line for reads. It sits opposite the L2 `*_L2_MEM` request ports and replaces the fixed-pattern memory stub in the top-level bench.

---
 rtl/l2_mem_responder_pkg.sv | 24 ++
 rtl/l2_mem_responder_if.sv | 37 +++
 rtl/l2_mem_responder_line_array.sv | 38 +++
 rtl/l2_mem_responder.sv | 125 ++++++++++++
 tb/tb_l2_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_mem_responder_pkg.sv
// Shared types and helpers for the L2-side main-memory responder.
// Line geometry, FSM states and the unwritten-line fill pattern.
package mem_pkg;

  localparam int LINE_W  = 512;
  localparam int INDEX_W = 8;
  localparam int TAG_W   = 18;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    RESP,
    GAP
  } mem_state_t;

  function automatic logic [LINE_W-1:0] init_line(
    input logic [31:0] line_addr,
    input logic [31:0] salt
  );
    return {16{line_addr ^ salt}};
  endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// Request/response bundle between the L2 controller and main memory.
// master = L2 controller side, slave = memory responder side.
interface l2_mem_if;
  import mem_pkg::*;

  logic               read_L2_MEM;
  logic               write_L2_MEM;
  logic [INDEX_W-1:0] index_L2_MEM;
  logic [TAG_W-1:0]   tag_L2_MEM;
  logic [TAG_W-1:0]   write_tag_L2_MEM;
  logic [LINE_W-1:0]  write_data_L2_MEM;
  logic               ready_MEM_L2;
  logic [LINE_W-1:0]  read_data_MEM_L2;

  modport master (
    output read_L2_MEM,
    output write_L2_MEM,
    output index_L2_MEM,
    output tag_L2_MEM,
    output write_tag_L2_MEM,
    output write_data_L2_MEM,
    input  ready_MEM_L2,
    input  read_data_MEM_L2
  );

  modport slave (
    input  read_L2_MEM,
    input  write_L2_MEM,
    input  index_L2_MEM,
    input  tag_L2_MEM,
    input  write_tag_L2_MEM,
    input  write_data_L2_MEM,
    output ready_MEM_L2,
    output read_data_MEM_L2
  );

endinterface

// File: rtl/l2_mem_responder_line_array.sv
// Backing store: sync-write, comb-read line array with per-line valid bits.
// Valid bits reset; line contents do not.
module mem_line_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [LINE_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [LINE_W-1:0]    rdata,
  output logic                 rvalid
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [LINE_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (we) begin
      vld[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem[raddr];
  assign rvalid = vld[raddr];

endmodule

// File: rtl/l2_mem_responder.sv
// Main-memory responder for L2 fills and write-backs.
// Fixed-latency FSM in front of a valid-tracked line store.
module l2_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] INIT_SALT = 32'hA5A5_0000
) (
  input logic      clk,
  input logic      rst,
  l2_mem_if.slave  bus
);

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  mem_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept, commit, load;

  logic                     rd_pend_q;
  logic [ADDR_BITS-1:0]     rd_addr_q, wr_addr_q;
  logic [LINE_W-1:0]        wr_data_q, rd_data_q;
  logic [LINE_W-1:0]        arr_rdata;
  logic                     arr_valid;
  logic                     ready_q;
  logic [TAG_W+INDEX_W-1:0] rd_full, wr_full;

  assign rd_full = {bus.tag_L2_MEM, bus.index_L2_MEM};
  assign wr_full = {bus.write_tag_L2_MEM, bus.index_L2_MEM};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.write_L2_MEM) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = WR_WAIT;
        end else if (bus.read_L2_MEM) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 8'd0) begin
          commit  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = rd_pend_q ? RD_WAIT : RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          load    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_q == RESP);
    end
  end

  // Latches are only ever loaded in IDLE, so mid-flight input churn is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (accept) begin
      rd_pend_q <= bus.read_L2_MEM;
      rd_addr_q <= ADDR_BITS'(rd_full);
      wr_addr_q <= ADDR_BITS'(wr_full);
      wr_data_q <= bus.write_data_L2_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (load) begin
      rd_data_q <= arr_valid ? arr_rdata
                 : init_line(32'(rd_addr_q), INIT_SALT);
    end
  end

  mem_line_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (wr_addr_q),
    .wdata  (wr_data_q),
    .raddr  (rd_addr_q),
    .rdata  (arr_rdata),
    .rvalid (arr_valid)
  );

  assign bus.ready_MEM_L2     = ready_q;
  assign bus.read_data_MEM_L2 = rd_data_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder at LATENCY=4 and LATENCY=1.
// Inputs driven and outputs sampled 1 time unit after rising edges.
module tb_l2_mem_responder;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  l2_mem_if b0 ();
  l2_mem_if b1 ();

  l2_mem_responder #(
    .LATENCY(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  l2_mem_responder #(
    .LATENCY(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [7:0] idx, input logic [17:0] tag,
                       input logic [17:0] wtag,
                       input logic [511:0] wd);
    if (sel) begin
      b1.read_L2_MEM       = rd;
      b1.write_L2_MEM      = wr;
      b1.index_L2_MEM      = idx;
      b1.tag_L2_MEM        = tag;
      b1.write_tag_L2_MEM  = wtag;
      b1.write_data_L2_MEM = wd;
    end else begin
      b0.read_L2_MEM       = rd;
      b0.write_L2_MEM      = wr;
      b0.index_L2_MEM      = idx;
      b0.tag_L2_MEM        = tag;
      b0.write_tag_L2_MEM  = wtag;
      b0.write_data_L2_MEM = wd;
    end
  endtask

  task automatic drop(input bit sel);
    if (sel) begin
      b1.read_L2_MEM  = 1'b0;
      b1.write_L2_MEM = 1'b0;
    end else begin
      b0.read_L2_MEM  = 1'b0;
      b0.write_L2_MEM = 1'b0;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b1.ready_MEM_L2 : b0.ready_MEM_L2;
  endfunction

  function automatic logic [511:0] rdat(input bit sel);
    return sel ? b1.read_data_MEM_L2 : b0.read_data_MEM_L2;
  endfunction

  // Issues one request; lat = edges after acceptance until ready (-1 on timeout).
  task automatic do_req(input bit sel, input bit rd, input bit wr,
                        input logic [7:0] idx, input logic [17:0] tag,
                        input logic [17:0] wtag,
                        input logic [511:0] wd,
                        output int lat, output logic [511:0] data,
                        output logic tail);
    drive(sel, rd, wr, idx, tag, wtag, wd);
    @(posedge clk);
    lat  = -1;
    data = '0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      #1;
      if (rdy(sel)) begin
        lat  = j;
        data = rdat(sel);
        break;
      end
    end
    drop(sel);
    @(posedge clk);
    #1;
    tail = rdy(sel);
  endtask

  task automatic test_reset();
    checks++;
    if (b0.ready_MEM_L2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", b0.ready_MEM_L2);
    end
    checks++;
    if (b0.read_data_MEM_L2 !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", b0.read_data_MEM_L2[31:0]);
    end
    checks++;
    if (b1.ready_MEM_L2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready1 got %b want 0", b1.ready_MEM_L2);
    end
    checks++;
    if (b1.read_data_MEM_L2 !== '0) begin
      errors++;
      $display("FAIL reset_data1 got %h want 0", b1.read_data_MEM_L2[31:0]);
    end
  endtask

  task automatic test_read_init();
    int lat;
    logic [511:0] d;
    logic t;
    do_req(0, 1, 0, 8'h05, 18'd0, 18'd0, '0, lat, d, t);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL rd_init_lat got %0d want 5", lat);
    end
    checks++;
    if (d !== {16{32'hA5A5_0005}}) begin
      errors++;
      $display("FAIL rd_init_data got %h want a5a50005", d[31:0]);
    end
    checks++;
    if (t !== 1'b0) begin
      errors++;
      $display("FAIL rd_init_width got %b want 0", t);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [511:0] d;
    logic t;
    do_req(0, 0, 1, 8'h10, 18'd0, 18'd1, {16{32'hDEAD_BEEF}}, lat, d, t);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL wr_lat got %0d want 5", lat);
    end
    checks++;
    if (d !== {16{32'hA5A5_0005}}) begin
      errors++;
      $display("FAIL wr_data_kept got %h want a5a50005", d[31:0]);
    end
    do_req(0, 1, 0, 8'h10, 18'd1, 18'd0, '0, lat, d, t);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL wr_rd_lat got %0d want 5", lat);
    end
    checks++;
    if (d !== {16{32'hDEAD_BEEF}}) begin
      errors++;
      $display("FAIL wr_rd_data got %h want deadbeef", d[31:0]);
    end
  endtask

  task automatic test_combined();
    int lat;
    logic [511:0] d;
    logic t;
    do_req(0, 1, 1, 8'h20, 18'd3, 18'd2, {16{32'h1234_5678}}, lat, d, t);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL comb_lat got %0d want 9", lat);
    end
    checks++;
    if (d !== {16{32'hA5A5_0320}}) begin
      errors++;
      $display("FAIL comb_data got %h want a5a50320", d[31:0]);
    end
    checks++;
    if (t !== 1'b0) begin
      errors++;
      $display("FAIL comb_width got %b want 0", t);
    end
    do_req(0, 1, 0, 8'h20, 18'd2, 18'd0, '0, lat, d, t);
    checks++;
    if (d !== {16{32'h1234_5678}}) begin
      errors++;
      $display("FAIL comb_later_data got %h want 12345678", d[31:0]);
    end
    do_req(0, 1, 1, 8'h40, 18'd4, 18'd4, {16{32'hCAFE_F00D}}, lat, d, t);
    checks++;
    if (d !== {16{32'hCAFE_F00D}}) begin
      errors++;
      $display("FAIL same_line_data got %h want cafef00d", d[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mask;
    mask = '0;
    drive(0, 1, 0, 8'h05, 18'd0, 18'd0, '0);
    @(posedge clk);
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      #1;
      mask[j] = b0.ready_MEM_L2;
    end
    drop(0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mask !== 32'h0008_1020) begin
      errors++;
      $display("FAIL b2b_pulses got %h want 00081020", mask);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [511:0] d;
    logic t;
    bit seen;
    drive(0, 0, 1, 8'h30, 18'd0, 18'd0, {16{32'h5555_AAAA}});
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drop(0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b0.ready_MEM_L2 !== 1'b0 || b0.read_data_MEM_L2 !== '0) begin
      errors++;
      $display("FAIL mid_rst_out got %b/%h want 0/0",
               b0.ready_MEM_L2, b0.read_data_MEM_L2[31:0]);
    end
    rst = 1'b0;
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (b0.ready_MEM_L2) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_pulse got %b want 0", seen);
    end
    do_req(0, 1, 0, 8'h30, 18'd0, 18'd0, '0, lat, d, t);
    checks++;
    if (d !== {16{32'hA5A5_0030}}) begin
      errors++;
      $display("FAIL mid_rst_data got %h want a5a50030", d[31:0]);
    end
  endtask

  task automatic test_latency1();
    int lat;
    logic [511:0] d;
    logic t;
    logic [31:0] mask;
    do_req(1, 1, 0, 8'h07, 18'd0, 18'd0, '0, lat, d, t);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL lat1_lat got %0d want 2", lat);
    end
    checks++;
    if (d !== {16{32'hA5A5_0007}}) begin
      errors++;
      $display("FAIL lat1_data got %h want a5a50007", d[31:0]);
    end
    mask = '0;
    drive(1, 1, 0, 8'h07, 18'd0, 18'd0, '0);
    @(posedge clk);
    for (int j = 1; j <= 11; j++) begin
      @(posedge clk);
      #1;
      mask[j] = b1.ready_MEM_L2;
    end
    drop(1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mask !== 32'h0000_0444) begin
      errors++;
      $display("FAIL lat1_b2b got %h want 00000444", mask);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 8'h00, 18'd0, 18'd0, '0);
    drive(1, 0, 0, 8'h00, 18'd0, 18'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_read_init();
    test_write_read();
    test_combined();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
